// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared constants, FSM encoding and cell index helper for the board colour controller
package board_pkg;

    localparam int DW    = 3;
    localparam int NCELL = 16;

    localparam logic [DW-1:0] RST_COLOR_DEFAULT = 3'b000;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Top-left cell is 15, index drops by 4 per column right and by 1 per row down.
    function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
        return ~{col, row};
    endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - two-flop synchroniser with single-cycle rising-edge pulse
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_edge;

    // Synchronise the asynchronous level, then remember the previous synchronised value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_edge;

endmodule

// File: rtl/board_color_ctrl.sv
// rtl/board_color_ctrl.sv - 16-cell colour board with button cursor, paint, clear sweep and blinking highlight
module board_color_ctrl
    import board_pkg::*;
#(
    parameter logic [DW-1:0] RST_COLOR = RST_COLOR_DEFAULT,
    parameter int            BLINK_DIV = 12_500_000,
    parameter int            HILITE_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          btn_paint,
    input  logic          btn_clear,
    input  logic [DW-1:0] color_sel,
    input  logic [3:0]    posicion,
    output logic [DW-1:0] dirColor,
    output logic [3:0]    cursor_idx,
    output logic          busy
);

    localparam int BW = $clog2(BLINK_DIV);

    logic w_pulse_up;
    logic w_pulse_down;
    logic w_pulse_left;
    logic w_pulse_right;
    logic w_pulse_paint;
    logic w_pulse_clear;

    btn_edge u_btn_up    (.clk(clk), .rst(rst), .i_btn(btn_up),    .o_pulse(w_pulse_up));
    btn_edge u_btn_down  (.clk(clk), .rst(rst), .i_btn(btn_down),  .o_pulse(w_pulse_down));
    btn_edge u_btn_left  (.clk(clk), .rst(rst), .i_btn(btn_left),  .o_pulse(w_pulse_left));
    btn_edge u_btn_right (.clk(clk), .rst(rst), .i_btn(btn_right), .o_pulse(w_pulse_right));
    btn_edge u_btn_paint (.clk(clk), .rst(rst), .i_btn(btn_paint), .o_pulse(w_pulse_paint));
    btn_edge u_btn_clear (.clk(clk), .rst(rst), .i_btn(btn_clear), .o_pulse(w_pulse_clear));

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_clr_addr;
    logic [3:0]    w_clr_addr_nxt;
    logic [1:0]    r_row;
    logic [1:0]    r_col;
    logic [1:0]    w_row_nxt;
    logic [1:0]    w_col_nxt;
    logic          w_wr_en;
    logic [3:0]    w_wr_addr;
    logic [DW-1:0] w_wr_data;

    logic [DW-1:0] r_cells [NCELL];

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink;

    logic [DW-1:0] w_cell;
    logic          w_hilite;

    assign cursor_idx = cell_idx(r_row, r_col);
    assign busy       = (r_state == CLEAR);

    // Next-state, cursor movement and cell write selection; one action per cycle, clear wins.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_wr_en        = 1'b0;
        w_wr_addr      = cell_idx(r_row, r_col);
        w_wr_data      = color_sel;
        if (r_state == CLEAR) begin
            // Sweep one cell per cycle; every button pulse is dropped here.
            w_wr_en        = 1'b1;
            w_wr_addr      = r_clr_addr;
            w_wr_data      = RST_COLOR;
            w_clr_addr_nxt = r_clr_addr + 4'd1;
            if (r_clr_addr == 4'd15) begin
                w_state_nxt = IDLE;
            end
        end else begin
            if (w_pulse_clear) begin
                w_state_nxt    = CLEAR;
                w_clr_addr_nxt = 4'd0;
            end else if (w_pulse_paint) begin
                w_wr_en = 1'b1;
            end else if (w_pulse_up) begin
                w_row_nxt = r_row - 2'd1;
            end else if (w_pulse_down) begin
                w_row_nxt = r_row + 2'd1;
            end else if (w_pulse_left) begin
                w_col_nxt = r_col - 2'd1;
            end else if (w_pulse_right) begin
                w_col_nxt = r_col + 2'd1;
            end
        end
    end

    // FSM state, sweep address and cursor registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_clr_addr <= 4'd0;
            r_row      <= 2'd0;
            r_col      <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
        end
    end

    // Cell storage: reset fills every cell, otherwise a single write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCELL; i++) begin
                r_cells[i] <= RST_COLOR;
            end
        end else if (w_wr_en) begin
            r_cells[w_wr_addr] <= w_wr_data;
        end
    end

    // Free-running blink divider; the phase flips each time the counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    // Display read port; the cursor cell is inverted while blinking, never during a sweep.
    always_comb begin
        w_cell   = r_cells[posicion];
        w_hilite = (HILITE_EN != 0) && r_blink && !busy && (posicion == cursor_idx);
        dirColor = w_hilite ? ~w_cell : w_cell;
    end

endmodule

// File: tb/tb_board_color_ctrl.sv
// tb/tb_board_color_ctrl.sv - scoreboard bench for board_color_ctrl
module tb_board_color_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] btns = 6'b0;
    logic [2:0] color_sel = 3'b000;
    logic [3:0] posicion = 4'd0;

    logic [2:0] dir_plain;
    logic [2:0] dir_hl;
    logic [3:0] cur_plain;
    logic [3:0] cur_hl;
    logic       busy_plain;
    logic       busy_hl;

    int checks   = 0;
    int failures = 0;
    int tb_cyc   = 0;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;
    exp_t exp_q[$];

    logic [2:0] m_cells [16];
    int         m_row = 0;
    int         m_col = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    board_color_ctrl #(.RST_COLOR(3'b000), .BLINK_DIV(4), .HILITE_EN(0)) u_plain (
        .clk(clk), .rst(rst),
        .btn_up(btns[0]), .btn_down(btns[1]), .btn_left(btns[2]), .btn_right(btns[3]),
        .btn_paint(btns[4]), .btn_clear(btns[5]),
        .color_sel(color_sel), .posicion(posicion),
        .dirColor(dir_plain), .cursor_idx(cur_plain), .busy(busy_plain)
    );

    board_color_ctrl #(.RST_COLOR(3'b000), .BLINK_DIV(4), .HILITE_EN(1)) u_hl (
        .clk(clk), .rst(rst),
        .btn_up(btns[0]), .btn_down(btns[1]), .btn_left(btns[2]), .btn_right(btns[3]),
        .btn_paint(btns[4]), .btn_clear(btns[5]),
        .color_sel(color_sel), .posicion(posicion),
        .dirColor(dir_hl), .cursor_idx(cur_hl), .busy(busy_hl)
    );

    function automatic int m_idx();
        return 15 - (4 * m_col + m_row);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [7:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk_cell(input int p, input string tag);
        posicion = 4'(p);
        #1;
        push_exp(tag, {5'd0, m_cells[p]});
        pop_chk({5'd0, dir_plain});
    endtask

    task automatic chk_cursor(input string tag);
        push_exp(tag, 8'(m_idx()));
        pop_chk({4'd0, cur_plain});
    endtask

    // b: 0 up, 1 down, 2 left, 3 right, 4 paint, 5 clear
    task automatic press(input int b);
        btns[b] = 1'b1;
        step(3);
        btns[b] = 1'b0;
        case (b)
            0: m_row = (m_row + 3) % 4;
            1: m_row = (m_row + 1) % 4;
            2: m_col = (m_col + 3) % 4;
            3: m_col = (m_col + 1) % 4;
            4: m_cells[m_idx()] = color_sel;
            default: ;
        endcase
        chk_cursor("cursor_after_press");
        step(3);
    endtask

    initial begin
        int         busy_cnt;
        logic [2:0] e3;

        for (int i = 0; i < 16; i++) m_cells[i] = 3'b000;

        // 1. reset
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk_cursor("reset_cursor");
        push_exp("reset_busy", 8'd0);
        pop_chk({7'd0, busy_plain});
        push_exp("reset_busy_hl", 8'd0);
        pop_chk({7'd0, busy_hl});
        for (int p = 0; p < 16; p++) chk_cell(p, "reset_cell");

        // 2. cursor moves and wrap-around
        press(3);
        press(3);
        press(3);
        press(3);
        press(1);
        press(0);
        press(0);
        press(1);

        // 3. paint at 15, then hold paint on 14 while colour changes
        color_sel = 3'b100;
        press(4);
        chk_cell(15, "paint_15");
        chk_cell(11, "untouched_11");
        press(1);
        color_sel = 3'b011;
        btns[4] = 1'b1;
        step(3);
        m_cells[m_idx()] = 3'b011;
        color_sel = 3'b110;
        step(17);
        btns[4] = 1'b0;
        step(3);
        chk_cell(14, "hold_paint_once");

        // 4. paint and right together: paint wins, move dropped
        press(0);
        press(3);
        color_sel = 3'b010;
        btns[4] = 1'b1;
        btns[3] = 1'b1;
        step(3);
        btns[4] = 1'b0;
        btns[3] = 1'b0;
        m_cells[m_idx()] = 3'b010;
        chk_cursor("priority_cursor");
        chk_cell(11, "priority_cell");
        step(3);

        // 5. paint 15, 10, 0 then clear
        press(2);
        color_sel = 3'b001;
        press(4);
        press(3);
        press(1);
        color_sel = 3'b111;
        press(4);
        press(3);
        press(3);
        press(1);
        press(1);
        color_sel = 3'b101;
        press(4);
        chk_cell(15, "pre_clear_15");
        chk_cell(10, "pre_clear_10");
        chk_cell(0,  "pre_clear_0");
        btns[5] = 1'b1;
        step(3);
        btns[5] = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 40 && busy_plain; k++) begin
            busy_cnt++;
            if (k == 1) btns[3] = 1'b1;
            step(1);
        end
        push_exp("busy_cycles", 8'd16);
        pop_chk(8'(busy_cnt));
        btns[3] = 1'b0;
        step(3);
        for (int i = 0; i < 16; i++) m_cells[i] = 3'b000;
        chk_cursor("cursor_after_clear");
        for (int p = 0; p < 16; p++) chk_cell(p, "cleared_cell");

        // 6. blink highlight on cursor cell 15
        press(1);
        press(3);
        color_sel = 3'b101;
        press(4);
        color_sel = 3'b011;
        press(1);
        press(4);
        press(0);
        posicion = 4'd15;
        #1;
        for (int k = 0; k < 12; k++) begin
            e3 = (((tb_cyc / 4) % 2) == 1) ? ~m_cells[15] : m_cells[15];
            push_exp("blink_15", {5'd0, e3});
            pop_chk({5'd0, dir_hl});
            step(1);
        end
        posicion = 4'd14;
        #1;
        for (int k = 0; k < 8; k++) begin
            push_exp("blink_14_steady", {5'd0, m_cells[14]});
            pop_chk({5'd0, dir_hl});
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
